// File: rtl/sabr_mul_pipe_rs_if.sv
// sabr_mul_pipe_rs_if
//   Operand/result stream bundle for the SABR pipelined multiplier.
//   Ports (signals):
//     in_valid, in_ready   - operand beat handshake
//     is_signed            - 1 = two's-complement beat, 0 = unsigned beat
//     din0, din1           - operands A and B
//     out_valid, out_ready - result handshake
//     dout, dout_sat       - scaled result and its saturation/loss flag
//   Modports:
//     master - upstream producer / downstream consumer side
//     slave  - the multiplier itself
interface sabr_mul_pipe_rs_if #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  is_signed;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic                  dout_sat;

  modport master (
    output in_valid, is_signed, din0, din1, out_ready,
    input  in_ready, out_valid, dout, dout_sat
  );

  modport slave (
    input  in_valid, is_signed, din0, din1, out_ready,
    output in_ready, out_valid, dout, dout_sat
  );
endinterface

// File: rtl/sabr_mul_pipe_rs.sv
// sabr_mul_pipe_rs
//   Pipelined signed/unsigned multiplier with round-half-up right shift,
//   saturation (or wrap) and overflow status, NUM_STAGE cycles of latency.
//   Ports:
//     clk        - clock, all state on rising edge
//     reset      - asynchronous active-low reset
//     ce         - global clock enable, 0 freezes all state
//     stat_clr   - synchronous clear of sat_sticky / sat_count
//     bus        - operand/result stream (sabr_mul_pipe_rs_if.slave)
//     sat_sticky - OR of all delivered dout_sat since reset/clear
//     sat_count  - number of saturated results delivered, stops at all-ones
module sabr_mul_pipe_rs #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 4,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 16,
  parameter int dout_WIDTH = 16,
  parameter int SHIFT      = 8,
  parameter int ROUND      = 1,
  parameter int SAT        = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 stat_clr,
  sabr_mul_pipe_rs_if.slave    bus,
  output logic                 sat_sticky,
  output logic [CNT_WIDTH-1:0] sat_count
);

  // P holds the exact product of the extended operands; R adds one guard bit
  // so the rounding constant can never overflow into the sign.
  localparam int P   = din0_WIDTH + din1_WIDTH + 1;
  localparam int R   = P + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [R-1:0] RND =
    (ROUND != 0 && SHIFT > 0) ? ({{(R-1){1'b0}}, 1'b1} << RSH) : '0;

  logic                 advance;
  logic signed [P-1:0]  a_ext;
  logic signed [P-1:0]  b_ext;
  logic signed [P-1:0]  prod;
  logic [P-1:0]         fin_prod;
  logic                 fin_signed;
  logic                 fin_valid;
  logic signed [R-1:0]  rounded;
  logic signed [R-1:0]  shifted;
  logic                 ovf;
  logic [dout_WIDTH-1:0] res;
  logic                 handshake;

  // The whole pipe moves as one: a held result at the output stalls every stage.
  assign advance      = ce & ~(bus.out_valid & ~bus.out_ready);
  assign bus.in_ready = advance;
  assign handshake    = bus.out_valid & bus.out_ready & ce;

  // Operand extension and exact multiply, computed ahead of the first register.
  always_comb begin
    a_ext = {{(P-din0_WIDTH){bus.is_signed & bus.din0[din0_WIDTH-1]}}, bus.din0};
    b_ext = {{(P-din1_WIDTH){bus.is_signed & bus.din1[din1_WIDTH-1]}}, bus.din1};
    prod  = a_ext * b_ext;
  end

  // Product stages: NUM_STAGE-1 registers carry the product, mode and valid;
  // the last stage (the output register) does the scaling.
  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign fin_prod   = prod;
      assign fin_signed = bus.is_signed;
      assign fin_valid  = bus.in_valid;
    end else begin : g_pipe
      logic [P-1:0]           prod_q [NUM_STAGE-1];
      logic [NUM_STAGE-2:0]   sgn_q;
      logic [NUM_STAGE-2:0]   vld_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sgn_q <= '0;
          vld_q <= '0;
          for (int k = 0; k < NUM_STAGE-1; k++) prod_q[k] <= '0;
        end else if (advance) begin
          vld_q[0]  <= bus.in_valid;
          sgn_q[0]  <= bus.is_signed;
          prod_q[0] <= prod;
          for (int k = 1; k < NUM_STAGE-1; k++) begin
            vld_q[k]  <= vld_q[k-1];
            sgn_q[k]  <= sgn_q[k-1];
            prod_q[k] <= prod_q[k-1];
          end
        end
      end

      assign fin_prod   = prod_q[NUM_STAGE-2];
      assign fin_signed = sgn_q[NUM_STAGE-2];
      assign fin_valid  = vld_q[NUM_STAGE-2];
    end
  endgenerate

  // Round half up, arithmetic shift, then range check. In unsigned mode the
  // shifted value is never negative, so only the bits above dout matter; in
  // signed mode everything from the dout sign bit upward must agree.
  always_comb begin
    rounded = {fin_prod[P-1], fin_prod} + RND;
    shifted = rounded >>> SHIFT;
    if (fin_signed) begin
      ovf = ~((&shifted[R-1:dout_WIDTH-1]) | ~(|shifted[R-1:dout_WIDTH-1]));
    end else begin
      ovf = |shifted[R-1:dout_WIDTH];
    end
    res = shifted[dout_WIDTH-1:0];
    if (SAT != 0 && ovf) begin
      if (fin_signed) begin
        res = shifted[R-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                           : {1'b0, {(dout_WIDTH-1){1'b1}}};
      end else begin
        res = '1;
      end
    end
  end

  // Output register: holds its contents whenever the pipe is not advancing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.out_valid <= 1'b0;
      bus.dout      <= '0;
      bus.dout_sat  <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= fin_valid;
      bus.dout      <= res;
      bus.dout_sat  <= ovf;
    end
  end

  // Saturation status counts delivered results only; a clear beats a
  // simultaneous saturated handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (ce) begin
      if (stat_clr) begin
        sat_sticky <= 1'b0;
        sat_count  <= '0;
      end else if (handshake && bus.dout_sat) begin
        sat_sticky <= 1'b1;
        if (sat_count != '1) sat_count <= sat_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sabr_mul_pipe_rs.sv
// tb_sabr_mul_pipe_rs
//   Directed, table-driven bench for sabr_mul_pipe_rs at the default
//   parameters (16x16 -> 16, SHIFT 8, ROUND 1, SAT 1, NUM_STAGE 4).
module tb_sabr_mul_pipe_rs;
  localparam int N = 4;

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_dout;
    logic        exp_sat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        stat_clr;
  logic        sat_sticky;
  logic [15:0] sat_count;

  vec_t vecs[16];
  int   checks = 0;
  int   errors = 0;

  sabr_mul_pipe_rs_if #(.din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(16)) bus ();

  sabr_mul_pipe_rs #(
    .ID(1), .NUM_STAGE(N), .din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(16),
    .SHIFT(8), .ROUND(1), .SAT(1), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .stat_clr(stat_clr), .bus(bus),
    .sat_sticky(sat_sticky), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic s, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid  = v;
    bus.is_signed = s;
    bus.din0      = a;
    bus.din1      = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int limit, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < limit) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int exp_cnt;
    int tx, rx, stall_left, stall_checks, cyc, extra;
    logic stall_armed, holding, prev_stall, accepted;
    logic [15:0] held_dout;
    logic held_sat;

    // sgn, a, b, expected dout, expected sat (all hand-computed)
    vecs[0]  = '{1'b1, 16'h0100, 16'h0100, 16'h0100, 1'b0};
    vecs[1]  = '{1'b1, 16'hFFFF, 16'h0080, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 16'hFFFF, 16'h0081, 16'hFFFF, 1'b0};
    vecs[3]  = '{1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[4]  = '{1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1};
    vecs[5]  = '{1'b0, 16'hFFFF, 16'h0002, 16'h0200, 1'b0};
    vecs[6]  = '{1'b1, 16'hFFFF, 16'h0002, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 16'h8000, 16'h8000, 16'h7FFF, 1'b1};
    vecs[8]  = '{1'b1, 16'h8000, 16'h7FFF, 16'h8000, 1'b1};
    vecs[9]  = '{1'b0, 16'h1234, 16'h0100, 16'h1234, 1'b0};
    vecs[10] = '{1'b1, 16'hFF00, 16'h0100, 16'hFF00, 1'b0};
    vecs[11] = '{1'b0, 16'h00FF, 16'h0101, 16'h0100, 1'b0};
    vecs[12] = '{1'b1, 16'h0001, 16'h0080, 16'h0001, 1'b0};
    vecs[13] = '{1'b1, 16'h7FFF, 16'h0100, 16'h7FFF, 1'b0};
    vecs[14] = '{1'b1, 16'h8000, 16'h0100, 16'h8000, 1'b0};
    vecs[15] = '{1'b0, 16'h8000, 16'h0200, 16'hFFFF, 1'b1};

    // Reset state
    reset = 1'b0; ce = 1'b1; stat_clr = 1'b0; bus.out_ready = 1'b1;
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) tick();
    check_output("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("rst_dout", {16'd0, bus.dout}, 32'd0);
    check_output("rst_dout_sat", {31'd0, bus.dout_sat}, 32'd0);
    check_output("rst_sticky", {31'd0, sat_sticky}, 32'd0);
    check_output("rst_count", {16'd0, sat_count}, 32'd0);
    reset = 1'b1;
    tick();

    // Table-driven single beats: latency, value, saturation and status
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, vecs[i].sgn, vecs[i].a, vecs[i].b);
      @(negedge clk);
      check_output("vec_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
      wait_out(20, lat);
      check_output($sformatf("vec%0d_latency", i), lat + 1, N);
      check_output($sformatf("vec%0d_dout", i), {16'd0, bus.dout}, {16'd0, vecs[i].exp_dout});
      check_output($sformatf("vec%0d_sat", i), {31'd0, bus.dout_sat}, {31'd0, vecs[i].exp_sat});
      if (vecs[i].exp_sat) exp_cnt++;
      tick();
      check_output($sformatf("vec%0d_drained", i), {31'd0, bus.out_valid}, 32'd0);
      check_output($sformatf("vec%0d_count", i), {16'd0, sat_count}, exp_cnt);
      check_output($sformatf("vec%0d_sticky", i), {31'd0, sat_sticky}, (exp_cnt != 0) ? 32'd1 : 32'd0);
    end

    // Status clear pulse
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_output("clr_count", {16'd0, sat_count}, 32'd0);
    check_output("clr_sticky", {31'd0, sat_sticky}, 32'd0);

    // Clear coinciding with a saturated handshake: clear wins
    apply_stimulus(1'b1, vecs[3].sgn, vecs[3].a, vecs[3].b);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
    wait_out(20, lat);
    check_output("clrwin_sat", {31'd0, bus.dout_sat}, 32'd1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_output("clrwin_count", {16'd0, sat_count}, 32'd0);
    check_output("clrwin_sticky", {31'd0, sat_sticky}, 32'd0);

    // Backpressure: 10 beats with random in_valid, out_ready low 5 cycles
    tx = 0; rx = 0; stall_left = 0; stall_checks = 0; cyc = 0;
    stall_armed = 1'b1; holding = 1'b0; prev_stall = 1'b0;
    held_dout = '0; held_sat = 1'b0;
    while (rx < 10 && cyc < 300) begin
      if (!holding) begin
        if (tx < 10 && $urandom_range(0, 1) == 1)
          apply_stimulus(1'b1, vecs[tx].sgn, vecs[tx].a, vecs[tx].b);
        else
          apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
      end
      bus.out_ready = (stall_left == 0);
      @(negedge clk);
      if (stall_left > 0) stall_left--;
      if (stall_armed && rx >= 2 && bus.out_valid) begin
        bus.out_ready = 1'b0;
        stall_left    = 4;
        stall_armed   = 1'b0;
      end
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        check_output("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        if (prev_stall) begin
          check_output("bp_dout_stable", {16'd0, bus.dout}, {16'd0, held_dout});
          check_output("bp_sat_stable", {31'd0, bus.dout_sat}, {31'd0, held_sat});
        end
        held_dout  = bus.dout;
        held_sat   = bus.dout_sat;
        prev_stall = 1'b1;
        stall_checks++;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        check_output($sformatf("bp%0d_dout", rx), {16'd0, bus.dout}, {16'd0, vecs[rx].exp_dout});
        check_output($sformatf("bp%0d_sat", rx), {31'd0, bus.dout_sat}, {31'd0, vecs[rx].exp_sat});
        rx++;
      end
      accepted = bus.in_valid & bus.in_ready;
      tick();
      cyc++;
      if (accepted) begin
        tx++;
        holding = 1'b0;
      end else begin
        holding = bus.in_valid;
      end
    end
    check_output("bp_received", rx, 10);
    check_output("bp_stall_seen", (stall_checks >= 5) ? 32'd1 : 32'd0, 32'd1);
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
    bus.out_ready = 1'b1;
    extra = 0;
    repeat (8) begin
      tick();
      if (bus.out_valid) extra++;
    end
    check_output("bp_no_extra", extra, 0);

    // Freeze: two beats in flight, ce low for 3 cycles
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    apply_stimulus(1'b1, vecs[3].sgn, vecs[3].a, vecs[3].b);
    tick();
    apply_stimulus(1'b1, vecs[0].sgn, vecs[0].a, vecs[0].b);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, vecs[5].sgn, vecs[5].a, vecs[5].b);
      @(negedge clk);
      check_output("frz_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_output("frz_out_valid", {31'd0, bus.out_valid}, 32'd0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
    ce = 1'b1;
    wait_out(20, lat);
    check_output("frz_resume_lat", lat, 1);
    check_output("frz_a_dout", {16'd0, bus.dout}, 32'h7FFF);
    ce = 1'b0;
    repeat (2) begin
      tick();
      check_output("frz_out_hold", {31'd0, bus.out_valid}, 32'd1);
      check_output("frz_dout_hold", {16'd0, bus.dout}, 32'h7FFF);
      check_output("frz_count_hold", {16'd0, sat_count}, 32'd0);
    end
    ce = 1'b1;
    tick();
    check_output("frz_b_valid", {31'd0, bus.out_valid}, 32'd1);
    check_output("frz_b_dout", {16'd0, bus.dout}, 32'h0100);
    check_output("frz_count_a", {16'd0, sat_count}, 32'd1);
    tick();
    check_output("frz_drained", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset with three beats in flight and a stalled output
    bus.out_ready = 1'b0;
    apply_stimulus(1'b1, vecs[4].sgn, vecs[4].a, vecs[4].b);
    tick();
    apply_stimulus(1'b1, vecs[3].sgn, vecs[3].a, vecs[3].b);
    tick();
    apply_stimulus(1'b1, vecs[8].sgn, vecs[8].a, vecs[8].b);
    tick();
    apply_stimulus(1'b0, 1'b0, 16'h0, 16'h0);
    wait_out(20, lat);
    check_output("rstf_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    check_output("rstf_pre_sticky", {31'd0, sat_sticky}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("rstf_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_output("rstf_dout", {16'd0, bus.dout}, 32'd0);
    check_output("rstf_count", {16'd0, sat_count}, 32'd0);
    check_output("rstf_sticky", {31'd0, sat_sticky}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    extra = 0;
    repeat (10) begin
      tick();
      if (bus.out_valid) extra++;
    end
    check_output("rstf_no_stale", extra, 0);
    check_output("rstf_in_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
